matching_unit: RTL and testbench

//  Waiting-matching store fed by the dispatcher's SEND_WR port (DEST_OPTION_LEFT/RIGHT operand tokens).

---
 rtl/matching_unit_pkg.sv | 33 +++
 rtl/matching_unit_table.sv | 53 +++++
 rtl/matching_unit.sv | 69 ++++++
 tb/tb_matching_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/matching_unit_pkg.sv
// matching_unit_pkg: shared option codes, token/request layouts and constructors for the matching unit.
package matching_unit_pkg;
   localparam int DEST_OPTION_WIDTH = 3;
   localparam int WORKER_RESULT_WIDTH = 67;
   localparam int PACKET_REQUEST_WIDTH = 99;
   localparam logic [DEST_OPTION_WIDTH-1:0] DEST_OPTION_NONE = 3'd0;
   localparam logic [DEST_OPTION_WIDTH-1:0] DEST_OPTION_LEFT = 3'd1;
   localparam logic [DEST_OPTION_WIDTH-1:0] DEST_OPTION_RIGHT = 3'd2;
   localparam logic [DEST_OPTION_WIDTH-1:0] DEST_OPTION_EXEC = 3'd3;
   typedef struct packed {
      logic [DEST_OPTION_WIDTH-1:0] option;
      logic [15:0] dest_addr;
      logic [15:0] color;
      logic [31:0] data;
   } worker_result_t;
   // side: 0 = LEFT operand, 1 = RIGHT operand; key is {dest_addr, color}
   typedef struct packed {
      logic side;
      logic [31:0] key;
      logic [31:0] data;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);
   function automatic logic [WORKER_RESULT_WIDTH-1:0] make_worker_result(
      input logic [DEST_OPTION_WIDTH-1:0] option, input logic [15:0] dest_addr,
      input logic [15:0] color, input logic [31:0] data);
      return {option, dest_addr, color, data};
   endfunction
   function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
      input logic [DEST_OPTION_WIDTH-1:0] option, input logic [15:0] dest_addr,
      input logic [15:0] color, input logic [31:0] data1, input logic [31:0] data2);
      return {option, dest_addr, color, data1, data2};
   endfunction
endpackage

// File: rtl/matching_unit_table.sv
// match_table: waiting operand storage with parallel key compare and lowest-index hit/free encoders.
module match_table
   import matching_unit_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int CNT_W = $clog2(ENTRIES + 1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               side,
   input  logic [31:0]        key,
   output logic               hit,
   output logic [31:0]        hit_data,
   output logic               free,
   input  logic               wr_en,
   input  logic [ENTRY_W-1:0] wr_entry,
   input  logic               clr_en,
   output logic [CNT_W-1:0]   occupancy
);
   localparam int IDX_W = $clog2(ENTRIES);
   entry_t ent [ENTRIES];
   logic [ENTRIES-1:0] valid;
   logic [IDX_W-1:0] hit_idx, free_idx;
   // scanning downward leaves the lowest matching / free index in place
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      free = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && ent[i].key == key && ent[i].side != side) begin
            hit = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid[i]) begin
            free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end
   assign hit_data = ent[hit_idx].data;
   always_ff @(posedge CLK) begin
      if (!RST) begin
         valid <= '0;
         occupancy <= '0;
      end else begin
         if (wr_en) valid[free_idx] <= 1'b1;
         if (clr_en) valid[hit_idx] <= 1'b0;
         occupancy <= occupancy + CNT_W'(wr_en) - CNT_W'(clr_en);
      end
   end
   always_ff @(posedge CLK) if (wr_en) ent[free_idx] <= entry_t'(wr_entry);
endmodule

// File: rtl/matching_unit.sv
// matching_unit: pairs LEFT/RIGHT operand tokens by {dest_addr,color} and emits EXEC packet requests.
module matching_unit
   import matching_unit_pkg::*;
#(
   parameter int ENTRIES = 8,
   localparam int CNT_W = $clog2(ENTRIES + 1)
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            RECEIVE_WR_VALID,
   input  logic [WORKER_RESULT_WIDTH-1:0]  RECEIVE_WR_DATA,
   output logic                            RECEIVE_WR_READY,
   output logic                            SEND_PR_VALID,
   output logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA,
   input  logic                            SEND_PR_READY,
   output logic [CNT_W-1:0]                OCCUPANCY,
   output logic                            ERROR_OVERFLOW,
   output logic                            ERROR_OPTION
);
   localparam logic [1:0] S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_EMIT = 2'd2;
   logic [1:0] state, state_nx;
   worker_result_t in_reg;
   logic is_left, is_right, bad, lookup, hit, free, wr_en, clr_en;
   logic [31:0] hit_data;
   assign is_left = in_reg.option == DEST_OPTION_LEFT;
   assign is_right = in_reg.option == DEST_OPTION_RIGHT;
   assign bad = !(is_left || is_right);
   assign lookup = state == S_LOOKUP;
   assign wr_en = lookup && !bad && !hit && free;
   assign clr_en = lookup && !bad && hit;
   assign RECEIVE_WR_READY = RST && state == S_IDLE;
   assign SEND_PR_VALID = state == S_EMIT;
   always_comb
      state_nx = (state == S_IDLE) ? (RECEIVE_WR_VALID ? S_LOOKUP : S_IDLE)
               : lookup ? (clr_en ? S_EMIT : S_IDLE)
               : (state == S_EMIT && !SEND_PR_READY) ? S_EMIT : S_IDLE;
   match_table #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) table_i (
      .CLK(CLK),
      .RST(RST),
      .side(is_right),
      .key({in_reg.dest_addr, in_reg.color}),
      .hit(hit),
      .hit_data(hit_data),
      .free(free),
      .wr_en(wr_en),
      .wr_entry({is_right, in_reg.dest_addr, in_reg.color, in_reg.data}),
      .clr_en(clr_en),
      .occupancy(OCCUPANCY)
   );
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= S_IDLE;
         in_reg <= '0;
         SEND_PR_DATA <= '0;
         ERROR_OVERFLOW <= 1'b0;
         ERROR_OPTION <= 1'b0;
      end else begin
         state <= state_nx;
         if (RECEIVE_WR_VALID && RECEIVE_WR_READY) in_reg <= RECEIVE_WR_DATA;
         // data1 is always the LEFT operand whichever side arrived first
         if (clr_en)
            SEND_PR_DATA <= make_packet_request(DEST_OPTION_EXEC, in_reg.dest_addr, in_reg.color,
                                                is_left ? in_reg.data : hit_data,
                                                is_left ? hit_data : in_reg.data);
         if (lookup && bad) ERROR_OPTION <= 1'b1;
         if (lookup && !bad && !hit && !free) ERROR_OVERFLOW <= 1'b1;
      end
   end
endmodule

// File: tb/tb_matching_unit.sv
// tb_matching_unit: directed and random tokens checked against a slot-array reference with a PR scoreboard.
module tb_matching_unit;
   import matching_unit_pkg::*;
   localparam int ENTRIES = 8;
   localparam int CNT_W = $clog2(ENTRIES + 1);
   logic clk = 1'b0, rst = 1'b0, wr_valid = 1'b0, wr_ready, pr_valid, pr_ready = 1'b0;
   logic [WORKER_RESULT_WIDTH-1:0] wr_data = '0;
   logic [PACKET_REQUEST_WIDTH-1:0] pr_data, held, e;
   logic [CNT_W-1:0] occ;
   logic err_ovf, err_opt, hold_low = 1'b0;
   int checks = 0, errors = 0;
   bit mv [ENTRIES];
   bit ms [ENTRIES];
   logic [31:0] mk [ENTRIES];
   logic [31:0] md [ENTRIES];
   bit me_ovf, me_opt;
   logic [PACKET_REQUEST_WIDTH-1:0] exp_q [$];

   matching_unit #(.ENTRIES(ENTRIES)) dut (
      .CLK(clk), .RST(rst), .RECEIVE_WR_VALID(wr_valid), .RECEIVE_WR_DATA(wr_data),
      .RECEIVE_WR_READY(wr_ready), .SEND_PR_VALID(pr_valid), .SEND_PR_DATA(pr_data),
      .SEND_PR_READY(pr_ready), .OCCUPANCY(occ), .ERROR_OVERFLOW(err_ovf), .ERROR_OPTION(err_opt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      pr_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [98:0] got, input logic [98:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   // monitor: every accepted PR must be the oldest expected one
   always @(negedge clk) begin
      if (rst && pr_valid && pr_ready) begin
         if (exp_q.size() == 0) chk("pr_unexpected", pr_data, '0);
         else begin
            e = exp_q.pop_front();
            chk("pr_data", pr_data, e);
         end
      end
   end

   function automatic int model_occ();
      int n = 0;
      for (int i = 0; i < ENTRIES; i++) n += int'(mv[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) mv[i] = 0;
      me_ovf = 0;
      me_opt = 0;
      exp_q.delete();
   endtask

   task automatic model(input logic [WORKER_RESULT_WIDTH-1:0] tok);
      worker_result_t t = worker_result_t'(tok);
      bit side = (t.option == DEST_OPTION_RIGHT);
      logic [31:0] key = {t.dest_addr, t.color};
      int h = -1, f = -1;
      if (t.option != DEST_OPTION_LEFT && t.option != DEST_OPTION_RIGHT) begin
         me_opt = 1;
         return;
      end
      for (int i = 0; i < ENTRIES; i++) begin
         if (h < 0 && mv[i] && mk[i] == key && ms[i] != side) h = i;
         if (f < 0 && !mv[i]) f = i;
      end
      if (h >= 0) begin
         mv[h] = 0;
         exp_q.push_back({DEST_OPTION_EXEC, key, side ? md[h] : t.data, side ? t.data : md[h]});
      end else if (f >= 0) begin
         mv[f] = 1;
         ms[f] = side;
         mk[f] = key;
         md[f] = t.data;
      end else me_ovf = 1;
   endtask

   task automatic drive(input logic [WORKER_RESULT_WIDTH-1:0] tok);
      int n = 0;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) begin
         chk("drive_timeout", wr_ready, 1);
         return;
      end
      wr_valid = 1'b1;
      wr_data = tok;
      @(posedge clk);
      #1 wr_valid = 1'b0;
      model(tok);
   endtask

   task automatic settle();
      int n = 0;
      @(negedge clk);
      while (!wr_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("settle_ready", wr_ready, 1);
      chk("occupancy", occ, model_occ());
      chk("error_overflow", err_ovf, me_ovf);
      chk("error_option", err_opt, me_opt);
   endtask

   task automatic send(input logic [2:0] o, input logic [15:0] d, input logic [15:0] c, input logic [31:0] x);
      drive(make_worker_result(o, d, c, x));
      settle();
   endtask

   task automatic wait_pr_valid();
      int n = 0;
      @(negedge clk);
      while (!pr_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pr_valid_wait", pr_valid, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      chk("rst_pr_valid", pr_valid, 0);
      chk("rst_occ", occ, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_pr_data", pr_data, 0);
      chk("rst_errors", {err_ovf, err_opt}, 0);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();
      // 1: LEFT then RIGHT
      send(DEST_OPTION_LEFT, 16'h1111, 16'h2222, 32'h33334444);
      chk("t1_occ1", occ, 1);
      send(DEST_OPTION_RIGHT, 16'h1111, 16'h2222, 32'h55556666);
      chk("t1_occ0", occ, 0);
      // 2: RIGHT first, operands still ordered LEFT/RIGHT in the request
      send(DEST_OPTION_RIGHT, 16'h0aaa, 16'h0bbb, 32'hdeadbeef);
      send(DEST_OPTION_LEFT, 16'h0aaa, 16'h0bbb, 32'hcafef00d);
      // 3: keys differing only in color
      send(DEST_OPTION_LEFT, 16'h1111, 16'h2222, 32'h00000001);
      send(DEST_OPTION_LEFT, 16'h1111, 16'h2223, 32'h00000002);
      send(DEST_OPTION_RIGHT, 16'h1111, 16'h2223, 32'h00000003);
      chk("t3_occ", occ, 1);
      // 4: fill, overflow, then a partner still pairs
      do_reset();
      for (int i = 0; i < ENTRIES; i++) send(DEST_OPTION_LEFT, 16'h0100 + 16'(i), 16'h0, 32'(i + 16));
      send(DEST_OPTION_LEFT, 16'h0200, 16'h0, 32'h99);
      chk("t4_overflow", err_ovf, 1);
      chk("t4_occ_full", occ, ENTRIES);
      send(DEST_OPTION_RIGHT, 16'h0103, 16'h0, 32'h77);
      // 5: back-pressure holds the request stable
      do_reset();
      hold_low = 1'b1;
      send(DEST_OPTION_LEFT, 16'h5555, 16'h0005, 32'h12345678);
      drive(make_worker_result(DEST_OPTION_RIGHT, 16'h5555, 16'h0005, 32'h9abcdef0));
      wait_pr_valid();
      held = pr_data;
      chk("t5_pr_data", held, {DEST_OPTION_EXEC, 16'h5555, 16'h0005, 32'h12345678, 32'h9abcdef0});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_valid_held", pr_valid, 1);
         chk("t5_data_stable", pr_data, held);
         chk("t5_wr_ready_low", wr_ready, 0);
      end
      hold_low = 1'b0;
      settle();
      // 6: bad option, then reset during emit
      send(DEST_OPTION_EXEC, 16'h0001, 16'h0001, 32'h1);
      chk("t6_error_option", err_opt, 1);
      hold_low = 1'b1;
      send(DEST_OPTION_RIGHT, 16'h0066, 16'h0006, 32'h6);
      drive(make_worker_result(DEST_OPTION_LEFT, 16'h0066, 16'h0006, 32'h60));
      wait_pr_valid();
      do_reset();
      hold_low = 1'b0;
      // random traffic over a small key space so hits, duplicates and overflow all occur
      for (int n = 0; n < 300; n++) begin
         int r = $urandom_range(0, 99);
         logic [2:0] o = r < 4 ? DEST_OPTION_EXEC : r < 8 ? DEST_OPTION_NONE
                       : r[0] ? DEST_OPTION_RIGHT : DEST_OPTION_LEFT;
         send(o, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 1)), $urandom);
      end
      settle();
      chk("scoreboard_drained", 99'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
